// File: rtl/ha_ow_reader_if.sv
// ha_ow_reader_if: valid/ready token stream from a solution output wrapper
// into the reader.
//   in_data  : token payload, DATA_BW bits
//   in_valid : source has a token this cycle
//   in_ready : reader accepts this cycle
// Modports: master = token source, slave = reader.
interface ha_ow_reader_if #(
    parameter int unsigned DATA_BW = 32
) ();
    logic [DATA_BW-1:0] in_data;
    logic               in_valid;
    logic               in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ha_ow_reader.sv
// ha_ow_reader: output-end reader for a DSE solution stream.
// Accepts tokens over a valid/ready stream into a small FIFO, counts a
// host-programmed frame of tokens, pulses done at the end of the frame and
// lets the host read captured tokens back one per request.
//
// Ports:
//   clk, rst           : clock, synchronous active-low reset
//   src (slave)        : in_data / in_valid / in_ready token stream
//   start, cfg_len     : frame start pulse and frame length (tokens)
//   busy, done         : frame running / one-cycle end-of-frame pulse
//   tok_cnt            : tokens accepted in the current or last frame
//   rd_en              : host read request
//   rd_data, rd_valid  : registered read data and its one-cycle strobe
//   count, empty, full : FIFO occupancy and flags
//   checksum           : XOR of tokens accepted in the frame
//
// Build option: define HA_OWR_CHECKSUM_EN to build the checksum register;
// otherwise checksum is tied to zero.
module ha_ow_reader #(
    parameter int unsigned DATA_BW = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_BW = 3
) (
    input  logic               clk,
    input  logic               rst,
    ha_ow_reader_if.slave      src,
    input  logic               start,
    input  logic [15:0]        cfg_len,
    output logic               busy,
    output logic               done,
    output logic [15:0]        tok_cnt,
    input  logic               rd_en,
    output logic [DATA_BW-1:0] rd_data,
    output logic               rd_valid,
    output logic [ADDR_BW:0]   count,
    output logic               empty,
    output logic               full,
    output logic [DATA_BW-1:0] checksum
);

    localparam int unsigned CNT_BW = ADDR_BW + 1;
    localparam int unsigned LEN_BW = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                busy_nxt;
    logic                done_nxt;

    logic [LEN_BW-1:0]   len_q;
    logic [ADDR_BW-1:0]  wr_ptr;
    logic [ADDR_BW-1:0]  rd_ptr;
    logic [CNT_BW-1:0]   count_nxt;
    logic [DATA_BW-1:0]  mem [DEPTH];

    logic                in_ready_int;
    logic                accept;
    logic                rd_fire;
    logic                start_take;
    logic                last_accept;

    // Ready depends only on registered state and the registered full flag.
    assign in_ready_int = (state == S_RUN) && !full;
    assign src.in_ready = in_ready_int;

    assign accept      = src.in_valid && in_ready_int;
    assign rd_fire     = rd_en && !empty;
    assign start_take  = (state == S_IDLE) && start;
    assign last_accept = accept && ((tok_cnt + LEN_BW'(1)) == len_q);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Next-state decode; busy/done are registered from the next state.
    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (cfg_len == LEN_BW'(0)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_accept) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        busy_nxt = (state_nxt == S_RUN);
        done_nxt = (state_nxt == S_DONE);
    end

    // Occupancy: a simultaneous accept and read leaves count unchanged.
    always_comb begin
        count_nxt = count;
        unique case ({accept, rd_fire})
            2'b10:   count_nxt = count + CNT_BW'(1);
            2'b01:   count_nxt = count - CNT_BW'(1);
            default: count_nxt = count;
        endcase
    end

    // Frame length latch and token counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q   <= '0;
            tok_cnt <= '0;
        end else if (start_take) begin
            len_q   <= cfg_len;
            tok_cnt <= '0;
        end else if (accept) begin
            tok_cnt <= tok_cnt + LEN_BW'(1);
        end
    end

    // Storage is not reset; contents persist across frames.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= src.in_data;
        end
    end

    // Pointers, occupancy flags and the registered read port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + ADDR_BW'(1);
            end
            if (rd_fire) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + ADDR_BW'(1);
            end
            rd_valid <= rd_fire;
            count    <= count_nxt;
            empty    <= (count_nxt == CNT_BW'(0));
            full     <= (count_nxt == CNT_BW'(DEPTH));
        end
    end

`ifdef HA_OWR_CHECKSUM_EN
    logic [DATA_BW-1:0] csum_q;

    // Running XOR of accepted tokens, cleared at each frame start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            csum_q <= '0;
        end else if (start_take) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= csum_q ^ src.in_data;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ha_ow_reader.sv
// tb_ha_ow_reader: directed self-checking bench for ha_ow_reader.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so each check sees the result of the preceding edge.
module tb_ha_ow_reader;

    localparam int unsigned DATA_BW = 32;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned ADDR_BW = 3;

`ifdef HA_OWR_CHECKSUM_EN
    localparam logic [31:0] CS_A = 32'h1;
`else
    localparam logic [31:0] CS_A = 32'h0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [15:0]        cfg_len;
    logic               busy;
    logic               done;
    logic [15:0]        tok_cnt;
    logic               rd_en;
    logic [DATA_BW-1:0] rd_data;
    logic               rd_valid;
    logic [ADDR_BW:0]   count;
    logic               empty;
    logic               full;
    logic [DATA_BW-1:0] checksum;

    int n_cmp = 0;
    int n_bad = 0;

    ha_ow_reader_if #(.DATA_BW(DATA_BW)) bus ();

    ha_ow_reader #(
        .DATA_BW (DATA_BW),
        .DEPTH   (DEPTH),
        .ADDR_BW (ADDR_BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src      (bus),
        .start    (start),
        .cfg_len  (cfg_len),
        .busy     (busy),
        .done     (done),
        .tok_cnt  (tok_cnt),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        cfg_len      = 16'd0;
        rd_en        = 1'b0;
        bus.in_data  = 32'h0;
        bus.in_valid = 1'b1;

        // Reset, then idle with in_valid held high.
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy",     32'(busy),         32'd0);
        chk("rst_done",     32'(done),         32'd0);
        chk("rst_tok_cnt",  32'(tok_cnt),      32'd0);
        chk("rst_rd_data",  rd_data,           32'd0);
        chk("rst_rd_valid", 32'(rd_valid),     32'd0);
        chk("rst_count",    32'(count),        32'd0);
        chk("rst_empty",    32'(empty),        32'd1);
        chk("rst_full",     32'(full),         32'd0);
        chk("rst_checksum", checksum,          32'd0);

        // Frame of 3 tokens back-to-back.
        bus.in_valid = 1'b0;
        start   = 1'b1;
        cfg_len = 16'd3;
        tick();
        start = 1'b0;
        chk("f3_busy",     32'(busy),         32'd1);
        chk("f3_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h11;
        tick();
        bus.in_data  = 32'h22;
        tick();
        chk("f3_no_done_yet", 32'(done), 32'd0);
        bus.in_data  = 32'h33;
        tick();
        bus.in_valid = 1'b0;
        chk("f3_done",     32'(done),    32'd1);
        chk("f3_busy_lo",  32'(busy),    32'd0);
        chk("f3_tok_cnt",  32'(tok_cnt), 32'd3);
        chk("f3_count",    32'(count),   32'd3);
        chk("f3_checksum", checksum,     32'h0);
        tick();
        chk("f3_done_pulse", 32'(done), 32'd0);
        chk("f3_tok_hold",   32'(tok_cnt), 32'd3);

        rd_en = 1'b1;
        tick();
        chk("f3_rd0_valid", 32'(rd_valid), 32'd1);
        chk("f3_rd0_data",  rd_data,       32'h11);
        tick();
        chk("f3_rd1_data",  rd_data,       32'h22);
        tick();
        chk("f3_rd2_valid", 32'(rd_valid), 32'd1);
        chk("f3_rd2_data",  rd_data,       32'h33);
        chk("f3_empty",     32'(empty),    32'd1);
        tick();
        chk("f3_rd_empty_valid", 32'(rd_valid), 32'd0);
        chk("f3_rd_empty_hold",  rd_data,       32'h33);
        rd_en = 1'b0;

        // Frame of 10 tokens into an 8-deep FIFO; pointers wrap.
        start   = 1'b1;
        cfg_len = 16'd10;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 32'hA0 + 32'(i);
            tick();
        end
        chk("f10_full",     32'(full),         32'd1);
        chk("f10_count8",   32'(count),        32'd8);
        chk("f10_ready_lo", 32'(bus.in_ready), 32'd0);
        chk("f10_tok8",     32'(tok_cnt),      32'd8);
        bus.in_data = 32'hA8;
        tick();
        chk("f10_stall_count", 32'(count),   32'd8);
        chk("f10_stall_tok",   32'(tok_cnt), 32'd8);

        // Full: read and valid together; only the read happens this edge.
        rd_en = 1'b1;
        tick();
        chk("f10_rdfull_count", 32'(count),         32'd7);
        chk("f10_rdfull_data",  rd_data,            32'hA0);
        chk("f10_rdfull_full",  32'(full),          32'd0);
        chk("f10_ready_back",   32'(bus.in_ready),  32'd1);
        chk("f10_tok_still8",   32'(tok_cnt),       32'd8);
        tick();
        chk("f10_cc_count", 32'(count),   32'd7);
        chk("f10_cc_data",  rd_data,      32'hA1);
        chk("f10_tok9",     32'(tok_cnt), 32'd9);
        bus.in_data = 32'hA9;
        tick();
        bus.in_valid = 1'b0;
        chk("f10_done",     32'(done),    32'd1);
        chk("f10_tok10",    32'(tok_cnt), 32'd10);
        chk("f10_count7",   32'(count),   32'd7);
        chk("f10_data_a2",  rd_data,      32'hA2);
        chk("f10_checksum", checksum,     CS_A);
        for (int j = 3; j < 10; j++) begin
            tick();
            chk("f10_drain", rd_data, 32'hA0 + 32'(j));
        end
        chk("f10_drained", 32'(empty), 32'd1);
        rd_en = 1'b0;

        // Zero-length frame: straight to DONE, nothing accepted.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h55;
        start   = 1'b1;
        cfg_len = 16'd0;
        tick();
        start = 1'b0;
        chk("z_done",     32'(done),         32'd1);
        chk("z_busy",     32'(busy),         32'd0);
        chk("z_ready",    32'(bus.in_ready), 32'd0);
        chk("z_checksum", checksum,          32'd0);
        tick();
        chk("z_done_lo", 32'(done),    32'd0);
        chk("z_count",   32'(count),   32'd0);
        chk("z_tok",     32'(tok_cnt), 32'd0);

        // start during RUN is ignored.
        bus.in_valid = 1'b0;
        start   = 1'b1;
        cfg_len = 16'd2;
        tick();
        cfg_len = 16'd5;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h61;
        tick();
        start = 1'b0;
        chk("ign_tok1", 32'(tok_cnt), 32'd1);
        bus.in_data = 32'h62;
        tick();
        bus.in_valid = 1'b0;
        chk("ign_done", 32'(done),    32'd1);
        chk("ign_tok2", 32'(tok_cnt), 32'd2);
        tick();

        // Reset mid-frame after 2 of 5 accepts.
        start   = 1'b1;
        cfg_len = 16'd5;
        tick();
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h71;
        tick();
        bus.in_data  = 32'h72;
        tick();
        chk("mr_count4", 32'(count),   32'd4);
        chk("mr_tok2",   32'(tok_cnt), 32'd2);
        rst = 1'b0;
        tick();
        chk("mr_count",  32'(count),         32'd0);
        chk("mr_busy",   32'(busy),          32'd0);
        chk("mr_tok",    32'(tok_cnt),       32'd0);
        chk("mr_done",   32'(done),          32'd0);
        chk("mr_empty",  32'(empty),         32'd1);
        chk("mr_ready",  32'(bus.in_ready),  32'd0);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        chk("mr_no_done", 32'(done), 32'd0);
        rd_en = 1'b1;
        tick();
        chk("mr_rd_valid", 32'(rd_valid), 32'd0);
        chk("mr_rd_data",  rd_data,       32'd0);
        rd_en = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
